// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage. Owns the fetch PC, reads one word
// per bus transaction and drives the IF/ID register consumed by decode.
//
// Ports:
//   clk, reset              clock, async active-high reset
//   stall, flush, new_pc    pipeline control: hold IF/ID, redirect
//   br_taken, br_addr       decoder branch redirect
//   bus_*                   bus-master handshake (active-low req/as/rdy/grnt)
//   if_pc, if_insn, if_en   IF/ID register outputs
module fetch_stage #(
  parameter int WORD_ADDR_W = 30,
  parameter int WORD_DATA_W = 32,
  parameter logic [WORD_ADDR_W-1:0] RESET_VECTOR = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   stall,
  input  logic                   flush,
  input  logic [WORD_ADDR_W-1:0] new_pc,
  input  logic                   br_taken,
  input  logic [WORD_ADDR_W-1:0] br_addr,
  output logic                   bus_req_,
  input  logic                   bus_grnt_,
  output logic                   bus_as_,
  output logic [WORD_ADDR_W-1:0] bus_addr,
  output logic                   bus_rw,
  output logic [WORD_DATA_W-1:0] bus_wr_data,
  input  logic [WORD_DATA_W-1:0] bus_rd_data,
  input  logic                   bus_rdy_,
  output logic [WORD_ADDR_W-1:0] if_pc,
  output logic [WORD_DATA_W-1:0] if_insn,
  output logic                   if_en
);

  typedef enum logic [1:0] {
    S_REQ,
    S_ACCESS,
    S_HOLD
  } state_t;

  state_t                 r_state;
  logic [WORD_ADDR_W-1:0] r_pc;
  logic [WORD_ADDR_W-1:0] r_fa;
  logic                   r_squash;
  logic                   r_first;
  logic [WORD_DATA_W-1:0] r_hb_insn;
  logic [WORD_ADDR_W-1:0] r_hb_pc;
  logic [WORD_ADDR_W-1:0] r_if_pc;
  logic [WORD_DATA_W-1:0] r_if_insn;
  logic                   r_if_en;

  logic                   w_done;
  logic                   w_grant;
  logic                   w_redir;
  logic [WORD_ADDR_W-1:0] w_tgt;

  assign w_done  = (r_state == S_ACCESS) && !bus_rdy_;
  assign w_grant = !bus_grnt_;
  // flush outranks stall; a branch only counts when IF/ID is not held
  assign w_redir = flush || (br_taken && !stall);
  assign w_tgt   = flush ? new_pc : br_addr;

  assign bus_req_    = (r_state == S_HOLD);
  assign bus_as_     = !((r_state == S_ACCESS) && r_first);
  assign bus_addr    = r_fa;
  assign bus_rw      = 1'b1;
  assign bus_wr_data = '0;

  assign if_pc   = r_if_pc;
  assign if_insn = r_if_insn;
  assign if_en   = r_if_en;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_REQ;
      r_pc      <= RESET_VECTOR;
      r_fa      <= RESET_VECTOR;
      r_squash  <= 1'b0;
      r_first   <= 1'b0;
      r_hb_insn <= '0;
      r_hb_pc   <= '0;
      r_if_pc   <= RESET_VECTOR;
      r_if_insn <= '0;
      r_if_en   <= 1'b0;
    end else begin
      r_first <= 1'b0;
      if (w_redir) begin
        r_pc    <= w_tgt;
        r_if_en <= 1'b0;
        if (flush) r_if_insn <= '0;
        case (r_state)
          S_REQ: begin
            // a grant in the redirect cycle fetches the target directly
            if (w_grant) begin
              r_fa    <= w_tgt;
              r_first <= 1'b1;
              r_state <= S_ACCESS;
            end
          end
          S_ACCESS: begin
            // the bus cycle is never aborted; its word is discarded
            if (w_done) begin
              r_squash <= 1'b0;
              r_state  <= S_REQ;
            end else begin
              r_squash <= 1'b1;
            end
          end
          default: r_state <= S_REQ;
        endcase
      end else begin
        if (!stall) r_if_en <= 1'b0;
        case (r_state)
          S_REQ: begin
            if (w_grant) begin
              r_fa    <= r_pc;
              r_first <= 1'b1;
              r_state <= S_ACCESS;
            end
          end
          S_ACCESS: begin
            if (w_done) begin
              if (r_squash) begin
                r_squash <= 1'b0;
                r_state  <= S_REQ;
              end else if (stall) begin
                r_hb_insn <= bus_rd_data;
                r_hb_pc   <= r_fa;
                r_state   <= S_HOLD;
              end else begin
                r_if_pc   <= r_fa;
                r_if_insn <= bus_rd_data;
                r_if_en   <= 1'b1;
                r_pc      <= r_fa + WORD_ADDR_W'(1);
                r_state   <= S_REQ;
              end
            end
          end
          S_HOLD: begin
            if (!stall) begin
              r_if_pc   <= r_hb_pc;
              r_if_insn <= r_hb_insn;
              r_if_en   <= 1'b1;
              r_pc      <= r_hb_pc + WORD_ADDR_W'(1);
              r_state   <= S_REQ;
            end
          end
          default: r_state <= S_REQ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: self-checking bench for fetch_stage with a
// wait-state bus slave model and a delivery scoreboard.
module tb_fetch_stage;

  localparam int AW = 30;
  localparam int DW = 32;
  localparam logic [AW-1:0] RV = 30'h100;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          stall = 1'b0;
  logic          flush = 1'b0;
  logic [AW-1:0] new_pc = '0;
  logic          br_taken = 1'b0;
  logic [AW-1:0] br_addr = '0;
  logic          bus_req_;
  logic          bus_grnt_;
  logic          bus_as_;
  logic [AW-1:0] bus_addr;
  logic          bus_rw;
  logic [DW-1:0] bus_wr_data;
  logic [DW-1:0] bus_rd_data;
  logic          bus_rdy_;
  logic [AW-1:0] if_pc;
  logic [DW-1:0] if_insn;
  logic          if_en;

  logic gnt_n = 1'b1;
  assign bus_grnt_ = gnt_n;

  fetch_stage #(
    .WORD_ADDR_W (AW),
    .WORD_DATA_W (DW),
    .RESET_VECTOR(RV)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .flush      (flush),
    .new_pc     (new_pc),
    .br_taken   (br_taken),
    .br_addr    (br_addr),
    .bus_req_   (bus_req_),
    .bus_grnt_  (bus_grnt_),
    .bus_as_    (bus_as_),
    .bus_addr   (bus_addr),
    .bus_rw     (bus_rw),
    .bus_wr_data(bus_wr_data),
    .bus_rd_data(bus_rd_data),
    .bus_rdy_   (bus_rdy_),
    .if_pc      (if_pc),
    .if_insn    (if_insn),
    .if_en      (if_en)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem(input logic [29:0] a);
    return {a, 2'b01} ^ 32'h5A5A_C3C3;
  endfunction

  // slave: strobe cycle is index 0, ready when index equals waits
  int   waits = 0;
  int   acc_cnt = 0;
  int   k;
  logic in_acc;
  assign in_acc = !bus_as_ || (acc_cnt != 0);
  assign k = bus_as_ ? acc_cnt : 0;
  assign bus_rdy_ = !(in_acc && (k == waits));
  assign bus_rd_data = bus_rdy_ ? 32'hDEAD_BEEF : mem(bus_addr);

  always @(posedge clk or posedge reset) begin
    if (reset) acc_cnt <= 0;
    else if (in_acc) acc_cnt <= (k == waits) ? 0 : k + 1;
  end

  typedef struct packed {
    logic [29:0] pc;
    logic [31:0] insn;
  } exp_t;

  typedef struct {
    int waits;
    int count;
    int gap;
  } vec_t;

  exp_t        exp_q[$];
  vec_t        vt[3];
  int          n_checks = 0;
  int          n_fail = 0;
  int          n_deliv = 0;
  int          target = 0;
  int          as_cnt = 0;
  int          gap_exp = 0;
  int          prev_cyc = 0;
  bit          have_prev = 0;
  logic [29:0] strobe_addr = '0;
  logic [29:0] m_pc;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [29:0] a);
    exp_q.push_back(exp_t'{pc: a, insn: mem(a)});
  endtask

  // one cycle: advance to negedge, then run the bus and IF/ID monitors
  task automatic step();
    exp_t e;
    @(negedge clk);
    if (!bus_as_) begin
      as_cnt++;
      strobe_addr = bus_addr;
    end
    if (!reset && !bus_rdy_)
      check("addr_stable", 64'(bus_addr), 64'(strobe_addr));
    if (!reset && if_en) begin
      n_deliv++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_delivery: got pc %0h expected none",
                 if_pc);
      end else begin
        e = exp_q.pop_front();
        check("if_pc", 64'(if_pc), 64'(e.pc));
        check("if_insn", 64'(if_insn), 64'(e.insn));
      end
      if (gap_exp != 0 && have_prev)
        check("deliv_gap", 64'(cyc - prev_cyc), 64'(gap_exp));
      prev_cyc  = cyc;
      have_prev = 1;
      if (n_deliv == target) gnt_n = 1'b1;
    end
  endtask

  task automatic wait_deliv(input int lim);
    for (int c = 0; c < lim && n_deliv < target; c++) step();
    check("deliv_count", 64'(n_deliv), 64'(target));
  endtask

  initial begin
    vt[0] = '{waits: 0, count: 2, gap: 2};
    vt[1] = '{waits: 3, count: 2, gap: 5};
    vt[2] = '{waits: 1, count: 1, gap: 3};

    step();
    check("rst_req", 64'(bus_req_), 64'(0));
    check("rst_as", 64'(bus_as_), 64'(1));
    check("rst_addr", 64'(bus_addr), 64'(RV));
    check("rst_if_pc", 64'(if_pc), 64'(RV));
    check("rst_if_insn", 64'(if_insn), 64'(0));
    check("rst_if_en", 64'(if_en), 64'(0));
    check("bus_rw", 64'(bus_rw), 64'(1));
    check("bus_wr_data", 64'(bus_wr_data), 64'(0));
    reset = 1'b0;
    step();

    m_pc = RV;
    for (int i = 0; i < 3; i++) begin
      waits = vt[i].waits;
      for (int j = 0; j < vt[i].count; j++) begin
        push(m_pc);
        m_pc = m_pc + 30'd1;
      end
      target    = target + vt[i].count;
      as_cnt    = 0;
      gap_exp   = vt[i].gap;
      have_prev = 0;
      gnt_n     = 1'b0;
      wait_deliv(100);
      check("as_per_fetch", 64'(as_cnt), 64'(vt[i].count));
    end
    gap_exp = 0;

    // stall across completion of 0x105
    waits = 2;
    push(30'h105);
    push(30'h106);
    target = target + 2;
    gnt_n = 1'b0;
    step();
    step();
    stall = 1'b1;
    step();
    step();
    check("hold_req", 64'(bus_req_), 64'(1));
    check("hold_if_pc", 64'(if_pc), 64'(30'h104));
    check("hold_if_en", 64'(if_en), 64'(0));
    step();
    check("hold_req2", 64'(bus_req_), 64'(1));
    step();
    stall = 1'b0;
    wait_deliv(60);
    check("stall_no_dup", 64'(exp_q.size()), 64'(0));

    // branch while 0x107 is in flight with 2 waits
    waits = 2;
    push(30'h200);
    target = target + 1;
    gnt_n = 1'b0;
    step();
    step();
    br_taken = 1'b1;
    br_addr  = 30'h200;
    step();
    br_taken = 1'b0;
    check("br_bubble", 64'(if_en), 64'(0));
    check("br_inflight", 64'(bus_addr), 64'(30'h107));
    wait_deliv(40);

    // flush + branch + stall together while 0x201 is in flight
    waits = 1;
    push(30'h040);
    target = target + 1;
    gnt_n = 1'b0;
    step();
    flush    = 1'b1;
    new_pc   = 30'h040;
    br_taken = 1'b1;
    br_addr  = 30'h300;
    stall    = 1'b1;
    step();
    flush    = 1'b0;
    br_taken = 1'b0;
    stall    = 1'b0;
    check("fl_if_en", 64'(if_en), 64'(0));
    check("fl_if_insn", 64'(if_insn), 64'(0));
    wait_deliv(40);

    // wrap from the top of the address space
    flush  = 1'b1;
    new_pc = 30'h3FFF_FFFF;
    step();
    flush = 1'b0;
    push(30'h3FFF_FFFF);
    push(30'h0);
    target    = target + 2;
    waits     = 0;
    gap_exp   = 2;
    have_prev = 0;
    gnt_n     = 1'b0;
    wait_deliv(40);
    gap_exp = 0;

    // asynchronous reset in the middle of an access
    waits = 3;
    target = target + 1;
    gnt_n = 1'b0;
    step();
    check("mid_as", 64'(bus_as_), 64'(0));
    check("mid_addr", 64'(bus_addr), 64'(30'h1));
    #2;
    reset = 1'b1;
    #1;
    check("arst_as", 64'(bus_as_), 64'(1));
    check("arst_req", 64'(bus_req_), 64'(0));
    check("arst_addr", 64'(bus_addr), 64'(RV));
    check("arst_if_pc", 64'(if_pc), 64'(RV));
    check("arst_if_insn", 64'(if_insn), 64'(0));
    check("arst_if_en", 64'(if_en), 64'(0));
    gnt_n = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();
    check("q_empty", 64'(exp_q.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
